// File: rtl/fifo_read_unloader_pkg.sv
// fifo_read_unloader_pkg
//   Constants shared between the FIFO read unloader, its output buffer and
//   any occupancy monitors.
//   OccWidth : width of the output-buffer occupancy count (holds 0..2).
package fifo_read_unloader_pkg;

    localparam int OccWidth = 2;

endpackage

// File: rtl/fifo_read_unloader_skid_buf2.sv
// skid_buf2
//   Two-entry in-order buffer with head/tail pointers and an entry count.
//   Sits behind a latency-1 FIFO read port and holds the words that arrive
//   before the downstream consumer takes them.
//   Ports:
//     RdClk  : clock, rising edge
//     Reset  : asynchronous active-high reset
//     Clear  : synchronous clear, drops every held word
//     Write  : append WrData at the tail
//     WrData : word to append
//     Pop    : remove the head word (ignored when empty)
//     Head   : head word (stale when Count is 0)
//     Count  : number of held words (0..2)
module skid_buf2
    import fifo_read_unloader_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic                RdClk,
    input  logic                Reset,
    input  logic                Clear,
    input  logic                Write,
    input  logic [Width-1:0]    WrData,
    input  logic                Pop,
    output logic [Width-1:0]    Head,
    output logic [OccWidth-1:0] Count
);

    logic [Width-1:0] mem [2];
    logic             wrPtr;
    logic             rdPtr;
    logic             doPop;
    logic             doWrite;

    assign doPop   = Pop & (Count != '0);
    // A write into a full buffer is only legal when the head leaves in the same cycle.
    assign doWrite = Write & ((Count != OccWidth'(2)) | doPop);
    assign Head    = mem[rdPtr];

    always_ff @(posedge RdClk or posedge Reset) begin
        if (Reset) begin
            // NOTE: the storage is reset as well, so the head word reads as zero
            // straight out of reset instead of whatever the flops powered up with.
            mem[0] <= '0;
            mem[1] <= '0;
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            Count  <= '0;
        end else if (Clear) begin
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            Count <= '0;
        end else begin
            // NOTE: every state update here is non-blocking, so all reads in this
            // block see the pre-edge values and the order of statements is irrelevant.
            if (doWrite) begin
                mem[wrPtr] <= WrData;
                wrPtr      <= ~wrPtr;
            end
            if (doPop) begin
                rdPtr <= ~rdPtr;
            end
            case ({doWrite, doPop})
                2'b10:   Count <= Count + OccWidth'(1);
                2'b01:   Count <= Count - OccWidth'(1);
                default: Count <= Count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_read_unloader.sv
// fifo_read_unloader
//   Turns a standard (latency-1, non-fall-through) FIFO read port into a
//   valid/ready stream at one word per cycle, counts delivered words and
//   flags FIFO-side protocol violations.
//   Ports:
//     RdClk     : clock, rising edge
//     Reset     : asynchronous active-high reset
//     Flush     : synchronous; drops buffered and in-flight words
//     FifoEmpty : FIFO empty flag
//     FifoRead  : pop request to the FIFO
//     FifoValid : FIFO data valid, one cycle after a pop
//     FifoDout  : FIFO read data
//     OutValid  : downstream word available
//     OutReady  : downstream accepts the word
//     OutData   : head word of the output buffer
//     WordCount : delivered words, wraps modulo 2^CountWidth
//     ProtoErr  : sticky, FifoValid seen with no pop in flight
//     Occupancy : output buffer entries (0..2)
module fifo_read_unloader
    import fifo_read_unloader_pkg::*;
#(
    parameter int Width      = 8,
    parameter int CountWidth = 16
) (
    input  logic                  RdClk,
    input  logic                  Reset,
    input  logic                  Flush,
    input  logic                  FifoEmpty,
    output logic                  FifoRead,
    input  logic                  FifoValid,
    input  logic [Width-1:0]      FifoDout,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [Width-1:0]      OutData,
    output logic [CountWidth-1:0] WordCount,
    output logic                  ProtoErr,
    output logic [OccWidth-1:0]   Occupancy
);

    logic [OccWidth-1:0] occ;
    logic                inFlight;
    logic                dropPending;
    logic                pop;
    logic                bufWrite;
    logic [2:0]          committed;

    assign OutValid  = (occ != '0);
    assign pop       = OutValid & OutReady;
    assign Occupancy = occ;

    // Words that will still be held or arriving after this cycle's pop; a new
    // FIFO pop is allowed only while that leaves room for its word.
    assign committed = {1'b0, occ} + {2'b00, inFlight} - {2'b00, pop};

    // Gated by Reset so the request is quiet while the block is held in reset.
    assign FifoRead  = ~Reset & ~FifoEmpty & ~Flush & (committed <= 3'd1);

    // A word arriving during Flush is dropped with the rest of the buffer.
    assign bufWrite  = FifoValid & inFlight & ~dropPending & ~Flush;

    skid_buf2 #(
        .Width (Width)
    ) u_buf (
        .RdClk  (RdClk),
        .Reset  (Reset),
        .Clear  (Flush),
        .Write  (bufWrite),
        .WrData (FifoDout),
        .Pop    (pop),
        .Head   (OutData),
        .Count  (occ)
    );

    always_ff @(posedge RdClk or posedge Reset) begin
        if (Reset) begin
            inFlight    <= 1'b0;
            dropPending <= 1'b0;
            ProtoErr    <= 1'b0;
            WordCount   <= '0;
        end else begin
            inFlight <= FifoRead;

            // The word of a pop still outstanding at Flush (not yet returned in
            // the Flush cycle itself) is swallowed when it turns up.
            if (Flush && inFlight && !FifoValid) begin
                dropPending <= 1'b1;
            end else if (FifoValid) begin
                dropPending <= 1'b0;
            end

            if (FifoValid && !inFlight && !dropPending) begin
                ProtoErr <= 1'b1;
            end

            if (pop) begin
                WordCount <= WordCount + CountWidth'(1);
            end
        end
    end

    // One word in the buffer plus one on the way is the most the pop rule allows.
    a_no_overflow : assert property (
        @(posedge RdClk) disable iff (Reset)
        ({1'b0, occ} + {2'b00, inFlight}) <= 3'd2
    );

endmodule

// File: tb/tb_fifo_read_unloader.sv
// tb_fifo_read_unloader
//   Drives fifo_read_unloader from a behavioural FIFO model and checks the
//   delivered stream against a scoreboard of popped words.
module tb_fifo_read_unloader;

    localparam int Width    = 8;
    localparam int CntW     = 4;
    localparam int LogDepth = 4096;

    logic             RdClk = 1'b0;
    logic             Reset;
    logic             Flush;
    logic             FifoEmpty;
    logic             FifoRead;
    logic             FifoValid;
    logic [Width-1:0] FifoDout;
    logic             OutValid;
    logic             OutReady;
    logic [Width-1:0] OutData;
    logic [CntW-1:0]  WordCount;
    logic             ProtoErr;
    logic [1:0]       Occupancy;

    fifo_read_unloader #(
        .Width      (Width),
        .CountWidth (CntW)
    ) dut (
        .RdClk     (RdClk),
        .Reset     (Reset),
        .Flush     (Flush),
        .FifoEmpty (FifoEmpty),
        .FifoRead  (FifoRead),
        .FifoValid (FifoValid),
        .FifoDout  (FifoDout),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutData   (OutData),
        .WordCount (WordCount),
        .ProtoErr  (ProtoErr),
        .Occupancy (Occupancy)
    );

    always #5 RdClk = ~RdClk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [Width-1:0] fifoQ[$];   // words still inside the FIFO
    logic [Width-1:0] expQ[$];    // popped from the FIFO, not yet delivered
    logic [Width-1:0] outQ[$];    // words delivered downstream, in order
    bit               prevRead;
    bit               expPe;
    bit               injReq;
    bit               injActive;
    bit               lastStall;
    logic [Width-1:0] lastOd;
    int               delivered;
    int               cyc;
    int               firstValidCyc;
    int               lastDelivCyc;
    int               validCycles;

    // Per-cycle violation tallies, inspected by the scenario tasks.
    int seqBad, occBad, readBad, peBad, stallBad;

    bit               rdLog  [LogDepth];
    bit               vLog   [LogDepth];
    logic [Width-1:0] dLog   [LogDepth];
    logic [1:0]       occLog [LogDepth];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_clear();
        fifoQ.delete();
        expQ.delete();
        outQ.delete();
        prevRead  = 0;
        expPe     = 0;
        injReq    = 0;
        injActive = 0;
        lastStall = 0;
        delivered = 0;
        seqBad = 0; occBad = 0; readBad = 0; peBad = 0; stallBad = 0;
    endfunction

    task automatic load(input logic [Width-1:0] w);
        fifoQ.push_back(w);
        FifoEmpty = 1'b0;
    endtask

    // One clock cycle: sample at the falling edge, update the FIFO model and
    // drive the next inputs just after the rising edge.
    task automatic tick();
        int               expOcc;
        bit               rd;
        bit               expRead;
        logic [Width-1:0] w;
        @(negedge RdClk);
        expOcc = expQ.size() - (prevRead ? 1 : 0);
        if (Occupancy !== 2'(expOcc) || OutValid !== (expOcc != 0)) occBad++;
        if (ProtoErr !== expPe) peBad++;
        if (lastStall && (OutValid !== 1'b1 || OutData !== lastOd)) stallBad++;
        if (cyc < LogDepth) begin
            rdLog[cyc]  = FifoRead;
            vLog[cyc]   = OutValid;
            dLog[cyc]   = OutData;
            occLog[cyc] = Occupancy;
        end
        if (OutValid === 1'b1) begin
            validCycles++;
            if (firstValidCyc < 0) firstValidCyc = cyc;
        end
        if (OutValid === 1'b1 && OutReady === 1'b1) begin
            if (expQ.size() == 0 || OutData !== expQ[0]) seqBad++;
            if (expQ.size() != 0) void'(expQ.pop_front());
            outQ.push_back(OutData);
            delivered++;
            lastDelivCyc = cyc;
        end
        lastStall = (OutValid === 1'b1) && (OutReady === 1'b0) && !Flush;
        lastOd    = OutData;
        if (Flush) expQ.delete();
        expRead = (fifoQ.size() != 0) && !Flush && (expQ.size() <= 1);
        if (FifoRead !== expRead) readBad++;
        rd = (FifoRead === 1'b1) && (fifoQ.size() != 0);
        w  = Width'($urandom);
        if (rd) begin
            w = fifoQ.pop_front();
            expQ.push_back(w);
        end
        @(posedge RdClk);
        #1;
        if (injActive) expPe = 1'b1;
        injActive = injReq;
        injReq    = 0;
        FifoValid = rd || injActive;
        FifoDout  = w;
        prevRead  = rd;
        FifoEmpty = (fifoQ.size() == 0);
        cyc++;
    endtask

    task automatic apply_reset();
        Reset     = 1'b1;
        Flush     = 1'b0;
        FifoValid = 1'b0;
        FifoEmpty = 1'b1;
        OutReady  = 1'b0;
        model_clear();
        repeat (2) @(posedge RdClk);
        @(negedge RdClk);
        Reset = 1'b0;
        @(posedge RdClk);
        #1;
    endtask

    task automatic check_tallies(input string name);
        checks++;
        if (seqBad !== 0 || occBad !== 0 || readBad !== 0 || peBad !== 0 || stallBad !== 0) begin
            errors++;
            $display("FAIL %s tallies: seq=%0d occ=%0d read=%0d perr=%0d stall=%0d, required all 0",
                     name, seqBad, occBad, readBad, peBad, stallBad);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (FifoRead !== 1'b0) begin errors++; $display("FAIL %s FifoRead: got %b want 0", name, FifoRead); end
        checks++;
        if (OutValid !== 1'b0) begin errors++; $display("FAIL %s OutValid: got %b want 0", name, OutValid); end
        checks++;
        if (OutData !== '0) begin errors++; $display("FAIL %s OutData: got %h want 00", name, OutData); end
        checks++;
        if (WordCount !== '0) begin errors++; $display("FAIL %s WordCount: got %0d want 0", name, WordCount); end
        checks++;
        if (ProtoErr !== 1'b0) begin errors++; $display("FAIL %s ProtoErr: got %b want 0", name, ProtoErr); end
        checks++;
        if (Occupancy !== 2'd0) begin errors++; $display("FAIL %s Occupancy: got %0d want 0", name, Occupancy); end
    endtask

    task automatic test_reset();
        Reset     = 1'b1;
        Flush     = 1'b0;
        FifoValid = 1'b0;
        FifoDout  = '0;
        FifoEmpty = 1'b0;   // FIFO claims data; the request must still stay low
        OutReady  = 1'b1;
        cyc       = 0;
        model_clear();
        #1;
        check_reset_outputs("reset");
        apply_reset();
        repeat (3) tick();
        check_tallies("reset_idle");
    endtask

    task automatic test_first_word();
        int t0;
        OutReady = 1'b1;
        load(8'hA5);
        t0 = cyc;
        repeat (4) tick();
        checks++;
        if (rdLog[t0] !== 1'b1) begin errors++; $display("FAIL first_read: got %b want 1", rdLog[t0]); end
        checks++;
        if (vLog[t0+1] !== 1'b0) begin errors++; $display("FAIL first_early_valid: got %b want 0", vLog[t0+1]); end
        checks++;
        if (vLog[t0+2] !== 1'b1 || dLog[t0+2] !== 8'hA5) begin
            errors++;
            $display("FAIL first_data: valid %b data %h, want 1 a5", vLog[t0+2], dLog[t0+2]);
        end
        checks++;
        if (WordCount !== 4'd1) begin errors++; $display("FAIL first_count: got %0d want 1", WordCount); end
        check_tallies("first_word");
    endtask

    task automatic test_stream();
        int target, n;
        OutReady = 1'b1;
        for (int i = 0; i < 16; i++) load(Width'(i));
        target = delivered + 16;
        firstValidCyc = -1;
        validCycles = 0;
        n = 0;
        while (delivered < target && n < 100) begin tick(); n++; end
        repeat (2) tick();
        checks++;
        if (delivered != target) begin errors++; $display("FAIL stream_done: got %0d words want %0d", delivered - target + 16, 16); end
        checks++;
        if (validCycles != 16 || lastDelivCyc - firstValidCyc != 15) begin
            errors++;
            $display("FAIL stream_gaps: valid cycles %0d span %0d, want 16 and 15", validCycles, lastDelivCyc - firstValidCyc);
        end
        checks++;
        if (WordCount !== CntW'(delivered)) begin errors++; $display("FAIL stream_count: got %0d want %0d", WordCount, CntW'(delivered)); end
        check_tallies("stream");
    endtask

    task automatic test_backpressure();
        int target, n, stallStart;
        bit readDuringStall;
        logic [1:0] maxOcc;
        for (int i = 0; i < 16; i++) load(Width'($urandom));
        target = delivered + 16;
        n = 0;
        while (delivered < target - 13 && n < 60) begin
            OutReady = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        OutReady = 1'b0;
        stallStart = cyc;
        repeat (5) tick();
        maxOcc = 0;
        readDuringStall = 0;
        for (int c = stallStart; c < stallStart + 5; c++) begin
            if (occLog[c] > maxOcc) maxOcc = occLog[c];
            if (c > stallStart && rdLog[c]) readDuringStall = 1;
        end
        OutReady = 1'b1;
        tick();
        checks++;
        if (maxOcc !== 2'd2) begin errors++; $display("FAIL bp_occupancy: got %0d want 2", maxOcc); end
        checks++;
        if (readDuringStall !== 1'b0) begin errors++; $display("FAIL bp_read_stall: got %b want 0", readDuringStall); end
        checks++;
        if (rdLog[stallStart+5] !== 1'b1) begin errors++; $display("FAIL bp_resume: got %b want 1", rdLog[stallStart+5]); end
        n = 0;
        while (delivered < target && n < 200) begin
            OutReady = ($urandom_range(0, 2) != 0);
            tick();
            n++;
        end
        OutReady = 1'b1;
        repeat (2) tick();
        checks++;
        if (delivered != target) begin errors++; $display("FAIL bp_done: got %0d want %0d", delivered, target); end
        check_tallies("backpressure");
    endtask

    task automatic test_flush();
        logic [Width-1:0] w[3];
        int target, n, tf, base;
        OutReady = 1'b1;
        for (int i = 0; i < 3; i++) begin w[i] = Width'($urandom); load(w[i]); end
        base = outQ.size();
        tick();                 // pop of w[0]
        Flush = 1'b1;
        tf = cyc;
        tick();                 // w[0] arrives while flushing
        Flush = 1'b0;
        target = delivered + 2;
        n = 0;
        while (delivered < target && n < 40) begin tick(); n++; end
        repeat (2) tick();
        checks++;
        if (vLog[tf+1] !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", vLog[tf+1]); end
        checks++;
        if (outQ.size() < base + 1 || outQ[base] !== w[1]) begin
            errors++;
            $display("FAIL flush_next: got %h want %h", (outQ.size() > base) ? outQ[base] : 'x, w[1]);
        end
        checks++;
        if (ProtoErr !== 1'b0) begin errors++; $display("FAIL flush_perr: got %b want 0", ProtoErr); end
        check_tallies("flush");
    endtask

    task automatic test_wrap();
        int n;
        apply_reset();
        for (int i = 0; i < 17; i++) load(Width'($urandom));
        n = 0;
        while (delivered < 17 && n < 120) begin
            OutReady = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        OutReady = 1'b1;
        repeat (2) tick();
        checks++;
        if (WordCount !== 4'd1) begin errors++; $display("FAIL wrap_count: got %0d want 1", WordCount); end
        check_tallies("wrap");
    endtask

    task automatic test_proto_err();
        int n, target;
        OutReady = 1'b1;
        injReq = 1;
        repeat (3) tick();
        checks++;
        if (ProtoErr !== 1'b1) begin errors++; $display("FAIL perr_set: got %b want 1", ProtoErr); end
        checks++;
        if (Occupancy !== 2'd0) begin errors++; $display("FAIL perr_occ: got %0d want 0", Occupancy); end
        for (int i = 0; i < 3; i++) load(Width'($urandom));
        target = delivered + 3;
        n = 0;
        while (delivered < target && n < 40) begin tick(); n++; end
        repeat (2) tick();
        checks++;
        if (ProtoErr !== 1'b1 || delivered != target) begin
            errors++;
            $display("FAIL perr_sticky: perr %b words %0d, want 1 and %0d", ProtoErr, delivered, target);
        end
        check_tallies("proto_err");
    endtask

    task automatic test_async_reset();
        int n;
        OutReady = 1'b1;
        for (int i = 0; i < 10; i++) load(Width'($urandom));
        repeat (5) tick();
        #2;
        Reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        FifoValid = 1'b0;
        apply_reset();
        OutReady = 1'b1;
        for (int i = 0; i < 2; i++) load(Width'($urandom));
        n = 0;
        while (delivered < 2 && n < 20) begin tick(); n++; end
        repeat (2) tick();
        checks++;
        if (delivered != 2 || WordCount !== 4'd2) begin
            errors++;
            $display("FAIL reset_recover: words %0d count %0d, want 2 and 2", delivered, WordCount);
        end
        check_tallies("async_reset");
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_stream();
        test_backpressure();
        test_flush();
        test_wrap();
        test_proto_err();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_read_unloader.md
# fifo_read_unloader

Read-side unloader for a standard (non-first-word-fall-through) FIFO read port. It issues `FifoRead` pops, absorbs the one-cycle read latency in a 2-entry output buffer, and presents the words downstream as a valid/ready stream at full throughput. It sits in the read clock domain between a FIFO's read interface (`Read`/`Dout`/`Valid`/`Empty`) and the consuming datapath. It also counts delivered words and flags protocol violations from the FIFO side.

## Interface
- `Width`, 8, data width in bits.
- `CountWidth`, 16, width of delivered-word counter.

- `RdClk`  in  1  clock; all logic on rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Flush`  in  1  synchronous; discards buffered and in-flight words.
- `FifoEmpty`  in  1  FIFO empty flag (standard mode).
- `FifoRead`  out  1  pop request to FIFO.
- `FifoValid`  in  1  FIFO data valid, one cycle after an accepted pop.
- `FifoDout`  in  Width  FIFO read data, qualified by `FifoValid`.
- `OutValid`  out  1  downstream word available.
- `OutReady`  in  1  downstream accepts word.
- `OutData`  out  Width  head word of output buffer.
- `WordCount`  out  CountWidth  words delivered (`OutValid & OutReady`), wraps modulo 2^CountWidth.
- `ProtoErr`  out  1  sticky: `FifoValid` seen with no pop in flight.
- `Occupancy`  out  2  output buffer entries (0..2).

## Operation
- State: 2-entry buffer `Occ` (0..2), `InFlight` (0/1, pop issued last cycle), `DropPending` (0/1).
- `Pop = OutValid & OutReady`.
- `FifoRead = ~FifoEmpty & ~Flush & (Occ + InFlight - Pop <= 1)`. It is purely combinational on current state and inputs, and is never asserted while `FifoEmpty`.
- `InFlight` next = `FifoRead`.
- When `FifoValid` arrives with `InFlight=1` and `DropPending=0`, the word is written to the buffer tail. Simultaneous write and `Pop` leaves `Occ` unchanged and keeps order (FIFO order is preserved).
- `FifoValid` with `InFlight=0` sets `ProtoErr` and the word is discarded. `ProtoErr` is cleared only by `Reset`.
- Overflow cannot occur by construction. An assertion checks `Occ + InFlight <= 2`.
- `OutValid = (Occ != 0)`. `OutData` is the head entry. Held data is stable while `OutValid & ~OutReady`.
- `Flush`:
  - `Occ` goes to 0 next cycle and no pop is issued in the `Flush` cycle.
  - If `InFlight=1`, set `DropPending`. The next `FifoValid` word is discarded without an error, then `DropPending` clears.
  - `Pop` in the `Flush` cycle still counts.
- `WordCount` increments on each `Pop` and wraps from 2^CountWidth-1 to 0.

## Timing
- Reset values: `FifoRead`=0, `OutValid`=0, `OutData`=0, `WordCount`=0, `ProtoErr`=0, `Occupancy`=0, `InFlight`=0, `DropPending`=0.
- Latency: `FifoRead` in cycle t, `FifoValid` in t+1, `OutValid` in t+2 (first word from idle).
- Throughput: 1 word/cycle sustained with `OutReady` held high and the FIFO non-empty.
- Backpressure: with `OutReady` low, at most 2 words are buffered and pops stop once `Occ + InFlight = 2`. Pops resume in the same cycle `OutReady` rises.
- `Reset` mid-operation: everything clears immediately. An in-flight word arriving after reset release is flagged by `ProtoErr`. The FIFO is expected to be reset together with this block.

## Structure
- Single module. The 2-entry buffer is a natural sub-module `skid_buf2` (write/pop/clear, head/tail pointers, count).
- Shared package holds no typedefs. Only the `Occupancy` width constant (2) is shared, for monitors.

## Test plan
- Idle then 1 word 0xA5 in FIFO, `OutReady`=1 → `FifoRead` at t, `OutValid`/`OutData`=0xA5 at t+2, `WordCount`=1.
- 16 words 0x00..0x0F, `OutReady`=1 → 16 consecutive `OutValid` cycles, in order, no gaps after the first.
- Same stream with `OutReady` low for 5 cycles mid-stream → `Occupancy` reaches 2, `FifoRead` stays low, no loss or duplication, and `OutData` is stable while stalled.
- `Flush` asserted in the cycle after a pop → the in-flight word is dropped, `OutValid`=0 next cycle, `ProtoErr` stays 0, and the next word delivered is the following FIFO entry.
- Inject `FifoValid`=1 with no prior `FifoRead` → `ProtoErr`=1 and stays set until `Reset`. `Occupancy` is unchanged.
- `CountWidth`=4, deliver 17 words → `WordCount`=1. Assert `Reset` asynchronously mid-stream → all outputs are at reset values before the next edge.
